// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready on both sides and a pipeline flush.
module alu_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       neg;
    } req_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    req_t               req_q;
    logic [W-1:0]       opb;
    logic [2*W-1:0]     acc;
    logic               accept, last;

    // Operand preparation on the request inputs
    logic         a_sgn, b_sgn, a_neg, b_neg, neg_in, div_zero, ovf;
    logic [W-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        a_sgn    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = a_sgn && A[W-1];
        b_neg    = b_sgn && B[W-1];
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
        // Remainder follows the dividend; everything else is the sign product.
        neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = op[2] && (B == '0);
        ovf      = op[2] && !op[0] && (A == {1'b1, {(W-1){1'b0}}}) && (B == '1);
        fast_res = div_zero ? (op[1] ? A : '1) : (op[1] ? '0 : A);
    end

    // One iteration step; acc is {hi, lo} for both engines.
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic           div_ok;
    logic [2*W-1:0] mul_next, div_next, acc_next, prod;
    logic [W-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[W-1:1]};
        div_shift = acc[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = !div_diff[W];
        div_next  = {div_ok ? div_diff[W-1:0] : div_shift[W-1:0], acc[W-2:0], div_ok};
        acc_next  = req_q.op[2] ? div_next : mul_next;
        prod      = req_q.neg ? -acc_next : acc_next;
        quo_s     = req_q.neg ? -acc_next[W-1:0]   : acc_next[W-1:0];
        rem_s     = req_q.neg ? -acc_next[2*W-1:W] : acc_next[2*W-1:W];
        case (req_q.op)
            3'b000:                 final_res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*W-1:W];
            3'b100, 3'b101:         final_res = quo_s;
            default:                final_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = (div_zero || ovf) ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                last = (cnt == CNT_W'(W-1));
                if (last) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            req_q  <= '0;
            opb    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt   <= '0;
            req_q <= '{op: op, neg: neg_in};
            // Multiply: multiplicand in opb, multiplier in lo. Divide: divisor in opb, dividend in lo.
            opb   <= op[2] ? b_mag : a_mag;
            acc   <= {{W{1'b0}}, op[2] ? a_mag : b_mag};
            if (div_zero || ovf) result <= fast_res;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_next;
            if (last) result <= final_res;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv at DATA_WIDTH 32 and 16,
// against a plain-arithmetic reference model.
module tb_alu_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic        sel16 = 1'b0, out_ready = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        rdy32, ov32, busy32, rdy16, ov16, busy16;
    logic [31:0] res32;
    logic [15:0] res16;
    logic        rdy, ov, bsy;
    logic [31:0] res;
    int          w = 32;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.DATA_WIDTH(32)) d32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid & ~sel16),
        .in_ready(rdy32), .op(op), .A(a), .B(b), .out_valid(ov32),
        .out_ready(out_ready), .result(res32), .busy(busy32));

    alu_muldiv #(.DATA_WIDTH(16)) d16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid & sel16),
        .in_ready(rdy16), .op(op), .A(a[15:0]), .B(b[15:0]), .out_valid(ov16),
        .out_ready(out_ready), .result(res16), .busy(busy16));

    assign rdy = sel16 ? rdy16 : rdy32;
    assign ov  = sel16 ? ov16 : ov32;
    assign bsy = sel16 ? busy16 : busy32;
    assign res = sel16 ? {16'd0, res16} : res32;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input int wd, input logic [2:0] o,
                                              input logic [31:0] av, input logic [31:0] bv);
        longint unsigned mask, ua, ub, p;
        longint sa, sb, minv;
        mask = (64'd1 << wd) - 64'd1;
        ua   = {32'd0, av} & mask;
        ub   = {32'd0, bv} & mask;
        sa   = av[wd-1] ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = bv[wd-1] ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        minv = -(longint'(1) << (wd-1));
        p    = 0;
        case (o)
            3'd0: p = ua * ub;
            3'd1: begin p = sa * sb; p = p >> wd; end
            3'd2: begin p = sa * longint'(ub); p = p >> wd; end
            3'd3: p = (ua * ub) >> wd;
            3'd4: if (ub == 0) p = mask; else if (sa == minv && sb == -1) p = ua; else p = sa / sb;
            3'd5: p = (ub == 0) ? mask : ua / ub;
            3'd6: if (ub == 0) p = ua; else if (sa == minv && sb == -1) p = 0; else p = sa % sb;
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    function automatic bit is_fast(input int wd, input logic [2:0] o,
                                   input logic [31:0] av, input logic [31:0] bv);
        longint unsigned mask, ua, ub;
        mask = (64'd1 << wd) - 64'd1;
        ua   = {32'd0, av} & mask;
        ub   = {32'd0, bv} & mask;
        return o[2] && (ub == 0 || (!o[0] && ua == (64'd1 << (wd-1)) && ub == mask));
    endfunction

    function automatic logic [31:0] rnd(input int wd);
        logic [31:0] mask;
        mask = 32'((64'd1 << wd) - 64'd1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1 << (wd-1);
            2:       return mask;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic accept(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        chk("in_ready_idle", 32'(rdy), 32'd1);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    endtask

    // Accept a request and wait (bounded) for out_valid; lat is the cycle index it appeared.
    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output int lat);
        int cyc;
        bit ir_bad;
        accept(o, av, bv);
        cyc = 1; ir_bad = 1'b0;
        while (!ov && cyc < 100) begin
            if (rdy) ir_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("in_ready_low", 32'(ir_bad), 32'd0);
        lat = cyc;
    endtask

    task automatic run_chk(input string tag, input logic [2:0] o, input logic [31:0] av,
                           input logic [31:0] bv);
        int lat;
        issue(o, av, bv, lat);
        chk(tag, res, ref_model(w, o, av, bv));
        chk({tag, "_lat"}, 32'(lat), is_fast(w, o, av, bv) ? 32'd1 : 32'(w + 1));
        @(posedge clk); #1;
    endtask

    logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                               32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] d_b  [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_r  [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD,
                               32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

    initial begin
        int lat;
        bit seen;
        logic [31:0] hold;
        #12;
        chk("rst_valid", 32'(ov32), 32'd0);
        chk("rst_busy", 32'(busy32), 32'd0);
        chk("rst_result", res32, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(rdy32), 32'd1);

        for (int i = 0; i < 12; i++) begin
            issue(d_op[i], d_a[i], d_b[i], lat);
            chk("dir_result", res, d_r[i]);
            chk("dir_lat", 32'(lat), (i >= 8) ? 32'd1 : 32'd33);
            @(posedge clk); #1;
        end

        // Backpressure, then a back-to-back request right after the consume edge
        out_ready = 1'b0;
        issue(3'd0, 32'd7, 32'hFFFFFFFD, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(ov), 32'd1);
            chk("bp_result", res, 32'hFFFFFFEB);
            chk("bp_ready", 32'(rdy), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(ov), 32'd0);
        run_chk("b2b", 3'd7, 32'd100, 32'd7);

        // Flush in DONE beats out_ready; result register keeps its value
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, lat);
        hold = res;
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_valid", 32'(ov), 32'd0);
        chk("flush_done_result", res, hold);

        // Request during flush in IDLE is dropped
        flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_busy", 32'(bsy), 32'd0);

        // Flush at BUSY cycle 10
        accept(3'd0, $urandom, $urandom);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_ready", 32'(rdy), 32'd1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen |= ov; end
        chk("flush_no_valid", 32'(seen), 32'd0);
        chk("flush_busy_result", res, hold);

        // Asynchronous reset at BUSY cycle 20
        accept(3'd1, $urandom, $urandom);
        repeat (19) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov), 32'd0);
        chk("arst_busy", 32'(bsy), 32'd0);
        chk("arst_result", res, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) run_chk("rnd32", 3'($urandom_range(0, 7)), rnd(32), rnd(32));

        sel16 = 1'b1; w = 16;
        @(posedge clk); #1;
        issue(3'd0, 32'h00FF, 32'h0101, lat);
        chk("w16_mul", res, 32'hFFFF);
        chk("w16_lat", 32'(lat), 32'd17);
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) run_chk("rnd16", 3'($urandom_range(0, 7)), rnd(16), rnd(16));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
